// File: rtl/gen_counter_pkg.sv
// Shared constants and helpers for the generic counter family.
//   MODE_WRAP / MODE_SAT : values for the SAT_MODE parameter
//   clamp_load           : limits a load value to the legal counting range
package gen_counter_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Out-of-range load values clamp to the top of the range.
    function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of updown_mod_counter.
//   master : drives clear, load, cnt_in, enable, up_dn; observes the count and flags
//   slave  : the counter side
interface updown_mod_counter_if #(
    parameter int unsigned WIDTH = 5
);

    logic             clear;
    logic             load;
    logic [WIDTH-1:0] cnt_in;
    logic             enable;
    logic             up_dn;
    logic [WIDTH-1:0] cnt_out;
    logic             at_max;
    logic             at_min;
    logic             tc;
    logic             wrap_evt;

    modport master (
        output clear, load, cnt_in, enable, up_dn,
        input  cnt_out, at_max, at_min, tc, wrap_evt
    );

    modport slave (
        input  clear, load, cnt_in, enable, up_dn,
        output cnt_out, at_max, at_min, tc, wrap_evt
    );

endinterface

// File: rtl/updown_step_calc.sv
// Combinational next count for one enabled step, up or down, with wrap or saturate.
//   cnt   : current count (0..MAX_VAL)
//   up_dn : 1 = up, 0 = down
//   nxt   : count after one STEP
//   ovf   : the step wrapped or saturated
module updown_step_calc #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned STEP     = 1,
    parameter bit          SAT_MODE = 1'b0
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             up_dn,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf
);

    // One spare bit so cnt+STEP and cnt+MAX_VAL+1 never truncate.
    localparam int unsigned EW     = WIDTH + 1;
    localparam logic [EW-1:0] MAX_E  = EW'(MAX_VAL);
    localparam logic [EW-1:0] STEP_E = EW'(STEP);
    localparam logic [EW-1:0] MOD_E  = MAX_E + EW'(1);

    logic [EW-1:0] cnt_e;
    logic [EW-1:0] sum_e;

    always_comb begin
        cnt_e = EW'(cnt);
        sum_e = cnt_e + STEP_E;
        nxt   = cnt;
        ovf   = 1'b0;
        if (up_dn) begin
            if (sum_e <= MAX_E) begin
                nxt = WIDTH'(sum_e);
            end else begin
                ovf = 1'b1;
                nxt = SAT_MODE ? WIDTH'(MAX_E) : WIDTH'(sum_e - MOD_E);
            end
        end else begin
            if (cnt_e >= STEP_E) begin
                nxt = WIDTH'(cnt_e - STEP_E);
            end else begin
                ovf = 1'b1;
                nxt = SAT_MODE ? '0 : WIDTH'(cnt_e + MOD_E - STEP_E);
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Loadable up/down counter with programmable modulus, step and wrap/saturate mode.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of updown_mod_counter_if
//              inputs  clear, load, cnt_in, enable, up_dn
//              outputs cnt_out (reg), wrap_evt (reg), at_max/at_min/tc (comb)
// tc is the carry/borrow for chaining: feed it to the next stage's enable.
module updown_mod_counter
    import gen_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned STEP     = 1,
    parameter bit          SAT_MODE = MODE_WRAP
) (
    input  logic                clk,
    input  logic                rst,
    updown_mod_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    // Elaboration-time parameter sanity; the load clamp works on 32-bit values.
    if (WIDTH < 2 || WIDTH > 31) begin : g_err_width
        $error("updown_mod_counter: WIDTH must be 2..31");
    end
    if (STEP == 0) begin : g_err_step_zero
        $error("updown_mod_counter: STEP must be nonzero");
    end
    if (STEP > MAX_VAL) begin : g_err_step_big
        $error("updown_mod_counter: STEP must not exceed MAX_VAL");
    end
    if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_err_max
        $error("updown_mod_counter: MAX_VAL does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_ovf;
    logic [WIDTH-1:0] load_val;
    logic             at_max_c;
    logic             at_min_c;

    updown_step_calc #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .STEP     (STEP),
        .SAT_MODE (SAT_MODE)
    ) u_step (
        .cnt   (cnt_q),
        .up_dn (bus.up_dn),
        .nxt   (step_nxt),
        .ovf   (step_ovf)
    );

    assign load_val = WIDTH'(clamp_load(32'(bus.cnt_in), 32'(MAX_VAL)));

    // Priority mux: clear > load > enable > hold (rst handled in the register).
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (bus.clear) begin
            cnt_d = '0;
        end else if (bus.load) begin
            cnt_d = load_val;
        end else if (bus.enable) begin
            cnt_d  = step_nxt;
            wrap_d = step_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign at_max_c     = (cnt_q == MAX_W);
    assign at_min_c     = (cnt_q == '0);
    assign bus.cnt_out  = cnt_q;
    assign bus.wrap_evt = wrap_q;
    assign bus.at_max   = at_max_c;
    assign bus.at_min   = at_min_c;
    assign bus.tc       = bus.enable & ~bus.load & ~bus.clear & (bus.up_dn ? at_max_c : at_min_c);

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;
    import gen_counter_pkg::*;

    localparam int unsigned W = 4;
    localparam int M = 9;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         clear;
    logic         load;
    logic         enable;
    logic         up_dn;
    logic [W-1:0] cnt_in;
    logic         chain_en;
    logic         chain_up;

    // Four single counters: (STEP, mode) = (1,wrap) (3,wrap) (1,sat) (3,sat)
    updown_mod_counter_if #(.WIDTH(W)) ifs [N] ();
    updown_mod_counter_if #(.WIDTH(W)) if_lo ();
    updown_mod_counter_if #(.WIDTH(W)) if_hi ();

    logic [W-1:0] got_cnt [N];
    logic         got_ev  [N];
    logic         got_max [N];
    logic         got_min [N];
    logic         got_tc  [N];

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign ifs[g].clear  = clear;
        assign ifs[g].load   = load;
        assign ifs[g].cnt_in = cnt_in;
        assign ifs[g].enable = enable;
        assign ifs[g].up_dn  = up_dn;
        assign got_cnt[g] = ifs[g].cnt_out;
        assign got_ev[g]  = ifs[g].wrap_evt;
        assign got_max[g] = ifs[g].at_max;
        assign got_min[g] = ifs[g].at_min;
        assign got_tc[g]  = ifs[g].tc;
    end

    updown_mod_counter #(.WIDTH(W), .MAX_VAL(M), .STEP(1), .SAT_MODE(MODE_WRAP))
        u_a (.clk(clk), .rst(rst), .bus(ifs[0]));
    updown_mod_counter #(.WIDTH(W), .MAX_VAL(M), .STEP(3), .SAT_MODE(MODE_WRAP))
        u_b (.clk(clk), .rst(rst), .bus(ifs[1]));
    updown_mod_counter #(.WIDTH(W), .MAX_VAL(M), .STEP(1), .SAT_MODE(MODE_SAT))
        u_c (.clk(clk), .rst(rst), .bus(ifs[2]));
    updown_mod_counter #(.WIDTH(W), .MAX_VAL(M), .STEP(3), .SAT_MODE(MODE_SAT))
        u_d (.clk(clk), .rst(rst), .bus(ifs[3]));

    // Decade chain: low stage tc enables the high stage.
    assign if_lo.clear  = 1'b0;
    assign if_lo.load   = 1'b0;
    assign if_lo.cnt_in = '0;
    assign if_lo.enable = chain_en;
    assign if_lo.up_dn  = chain_up;
    assign if_hi.clear  = 1'b0;
    assign if_hi.load   = 1'b0;
    assign if_hi.cnt_in = '0;
    assign if_hi.enable = if_lo.tc;
    assign if_hi.up_dn  = chain_up;

    updown_mod_counter #(.WIDTH(W), .MAX_VAL(M), .STEP(1), .SAT_MODE(MODE_WRAP))
        u_lo (.clk(clk), .rst(rst), .bus(if_lo));
    updown_mod_counter #(.WIDTH(W), .MAX_VAL(M), .STEP(1), .SAT_MODE(MODE_WRAP))
        u_hi (.clk(clk), .rst(rst), .bus(if_hi));

    // Reference model state
    int mcnt [N];
    bit mev  [N];
    int mchain;
    bit mlo_ev;
    bit mhi_ev;

    int n_cmp = 0;
    int n_err = 0;
    int hi_pulses;

    function automatic int step_of(input int i);
        return (i % 2 == 1) ? 3 : 1;
    endfunction

    function automatic bit sat_of(input int i);
        return (i >= 2);
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Value arithmetic straight from the behavioural rules.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            int s = step_of(i);
            int c = mcnt[i];
            bit e = 1'b0;
            if (rst || clear) begin
                c = 0;
            end else if (load) begin
                c = (int'(cnt_in) > M) ? M : int'(cnt_in);
            end else if (enable) begin
                if (up_dn) begin
                    if (c + s > M) begin
                        e = 1'b1;
                        c = sat_of(i) ? M : c + s - (M + 1);
                    end else begin
                        c = c + s;
                    end
                end else begin
                    if (c < s) begin
                        e = 1'b1;
                        c = sat_of(i) ? 0 : c + (M + 1) - s;
                    end else begin
                        c = c - s;
                    end
                end
            end
            mcnt[i] = c;
            mev[i]  = e;
        end
        // Chain behaves as one modulo-100 counter.
        mlo_ev = 1'b0;
        mhi_ev = 1'b0;
        if (rst) begin
            mchain = 0;
        end else if (chain_en) begin
            if (chain_up) begin
                mlo_ev = (mchain % 10 == 9);
                mhi_ev = (mchain == 99);
                mchain = (mchain + 1) % 100;
            end else begin
                mlo_ev = (mchain % 10 == 0);
                mhi_ev = (mchain == 0);
                mchain = (mchain + 99) % 100;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            bit etc = enable && !load && !clear && (up_dn ? (mcnt[i] == M) : (mcnt[i] == 0));
            check_eq($sformatf("cnt%0d", i), int'(got_cnt[i]), mcnt[i]);
            check_eq($sformatf("wrap%0d", i), int'(got_ev[i]), int'(mev[i]));
            check_eq($sformatf("max%0d", i), int'(got_max[i]), int'(mcnt[i] == M));
            check_eq($sformatf("min%0d", i), int'(got_min[i]), int'(mcnt[i] == 0));
            check_eq($sformatf("tc%0d", i), int'(got_tc[i]), int'(etc));
        end
        check_eq("chain_lo", int'(if_lo.cnt_out), mchain % 10);
        check_eq("chain_hi", int'(if_hi.cnt_out), mchain / 10);
        check_eq("chain_lo_wrap", int'(if_lo.wrap_evt), int'(mlo_ev));
        check_eq("chain_hi_wrap", int'(if_hi.wrap_evt), int'(mhi_ev));
        check_eq("chain_lo_tc", int'(if_lo.tc),
                 int'(chain_en && (chain_up ? (mchain % 10 == 9) : (mchain % 10 == 0))));
    endtask

    // Inputs are set at the falling edge before calling; checks run 1 time unit later.
    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (if_hi.wrap_evt === 1'b1) hi_pulses++;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; clear = 1'b0; load = 1'b0; enable = 1'b0; up_dn = 1'b1;
        cnt_in = '0; chain_en = 1'b0; chain_up = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mcnt[i] = 0;
            mev[i]  = 1'b0;
        end
        mchain = 0; mlo_ev = 1'b0; mhi_ev = 1'b0; hi_pulses = 0;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("rst_cnt", int'(got_cnt[0]), 0);
        check_eq("rst_min", int'(got_min[0]), 1);
        check_eq("rst_max", int'(got_max[0]), 0);
        check_eq("rst_tc", int'(got_tc[0]), 0);

        // Wrap up through 9 -> 0 on the STEP=1 counter.
        rst = 1'b0; enable = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check_eq("t1_end_cnt", int'(got_cnt[0]), 0);
        check_eq("t1_end_wrap", int'(got_ev[0]), 1);

        // Down from 0 with STEP=3: 7, 4, 1, 8.
        do_reset();
        enable = 1'b1; up_dn = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_eq("t2_end_cnt", int'(got_cnt[1]), 8);
        check_eq("t2_end_wrap", int'(got_ev[1]), 1);

        // Saturation: load 8, up 3 cycles pins at 9; down from 1 by 3 pins at 0.
        idle_inputs(); load = 1'b1; cnt_in = W'(8);
        tick();
        load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check_eq("t3_sat_cnt", int'(got_cnt[2]), 9);
        check_eq("t3_sat_wrap", int'(got_ev[2]), 1);
        idle_inputs(); load = 1'b1; cnt_in = W'(1);
        tick();
        load = 1'b0; enable = 1'b1; up_dn = 1'b0;
        tick();
        check_eq("t3_satdn_cnt", int'(got_cnt[3]), 0);
        check_eq("t3_satdn_wrap", int'(got_ev[3]), 1);

        // Priority combinations.
        idle_inputs(); rst = 1'b1; clear = 1'b1; load = 1'b1; enable = 1'b1; cnt_in = W'(5);
        tick();
        check_eq("t4_all_cnt", int'(got_cnt[0]), 0);
        idle_inputs(); clear = 1'b1; load = 1'b1; cnt_in = W'(5);
        tick();
        check_eq("t4_clrld_cnt", int'(got_cnt[0]), 0);
        idle_inputs(); load = 1'b1; enable = 1'b1; cnt_in = W'(5);
        tick();
        check_eq("t4_ld_en_cnt", int'(got_cnt[0]), 5);
        idle_inputs(); load = 1'b1; cnt_in = W'(15);
        tick();
        check_eq("t4_clamp_cnt", int'(got_cnt[0]), 9);

        // Decade chain, 100 up counts.
        do_reset();
        chain_en = 1'b1; chain_up = 1'b1; hi_pulses = 0;
        for (int k = 0; k < 99; k++) tick();
        check_eq("t5_c99_hi", int'(if_hi.cnt_out), 9);
        check_eq("t5_c99_lo", int'(if_lo.cnt_out), 9);
        tick();
        check_eq("t5_c100_hi", int'(if_hi.cnt_out), 0);
        check_eq("t5_c100_lo", int'(if_lo.cnt_out), 0);
        check_eq("t5_hi_pulses", hi_pulses, 1);

        // Reset mid-count overrides enable.
        do_reset();
        enable = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check_eq("t6_pre_cnt", int'(got_cnt[0]), 6);
        rst = 1'b1;
        tick();
        check_eq("t6_rst_cnt", int'(got_cnt[0]), 0);
        check_eq("t6_rst_wrap", int'(got_ev[0]), 0);
        rst = 1'b0;
        tick();
        tick();
        check_eq("t6_resume_cnt", int'(got_cnt[0]), 2);

        // Randomized traffic against the model.
        for (int k = 0; k < 500; k++) begin
            rst      = ($urandom_range(0, 49) == 0);
            clear    = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 7) == 0);
            enable   = ($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom);
            cnt_in   = W'($urandom);
            chain_en = ($urandom_range(0, 3) != 0);
            chain_up = ($urandom_range(0, 7) != 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
